instruction_sequencer: RTL and testbench

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/instruction_sequencer_pkg.sv | 19 +
 rtl/instruction_sequencer_program_memory.sv | 28 ++
 rtl/instruction_sequencer.sv | 152 +++++++++++++++
 tb/tb_instruction_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared types and default constants for the instruction sequencer.
// The PAUSED state exists only when INSTR_SEQ_BREAKPOINT_EN is defined.
package instruction_sequencer_pkg;

   localparam logic [15:0] SEQ_DEFAULT_NOP_INSTR  = 16'h9000;
   localparam logic [15:0] SEQ_DEFAULT_END_MARKER = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_ISSUE = 3'd2,
      ST_DONE  = 3'd3
`ifdef INSTR_SEQ_BREAKPOINT_EN
      ,
      ST_PAUSED = 3'd4
`endif
   } seq_state_e;

endpackage

// File: rtl/instruction_sequencer_program_memory.sv
// Program store: one write port and a registered (one-cycle latency) read port.
// Contents are deliberately not reset.
module program_memory #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 1024,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clock_i,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clock_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instruction_sequencer.sv
// Fetches program words from program_memory and issues one per cycle to a consumer.
// Optional breakpoint/resume support is enabled by defining INSTR_SEQ_BREAKPOINT_EN.
//
// state  | meaning
// IDLE   | not running; program memory writable
// FETCH  | first read of address 0 in flight
// ISSUE  | fetched word available; issue, stall, or stop on end marker
// DONE   | program finished; memory writable, count readable
// PAUSED | breakpoint hit before issuing mem[pc] (breakpoint build only)
module instruction_sequencer
   import instruction_sequencer_pkg::*;
#(
   parameter int                     INSTR_WIDTH = 16,
   parameter int                     DEPTH       = 1024,
   parameter logic [INSTR_WIDTH-1:0] END_MARKER  = SEQ_DEFAULT_END_MARKER,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = SEQ_DEFAULT_NOP_INSTR,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                   clock_in,
   input  logic                   reset_n_in,
   input  logic                   load_enable_in,
   input  logic [AW-1:0]          load_address_in,
   input  logic [INSTR_WIDTH-1:0] load_data_in,
   input  logic                   start_in,
   input  logic                   abort_in,
   input  logic                   stall_in,
`ifdef INSTR_SEQ_BREAKPOINT_EN
   input  logic                   breakpoint_enable_in,
   input  logic [AW-1:0]          breakpoint_address_in,
   input  logic                   resume_in,
`endif
   output logic [INSTR_WIDTH-1:0] current_instruction_out,
   output logic                   instruction_valid_out,
   output logic [AW:0]            instruction_count_out,
   output logic                   running_out,
   output logic                   done_out
);

   localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

   seq_state_e             state_q, state_d;
   logic [AW-1:0]          pc_q, pc_d;
   logic [AW:0]            count_q, count_d;
   logic                   valid_q, valid_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [INSTR_WIDTH-1:0] rd_data;
   logic                   mem_we;
   logic                   issue;

   assign mem_we = load_enable_in && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   // Reading at pc_d keeps the next word ready: pc+1 after an issue, pc on a hold.
   program_memory #(
      .WIDTH (INSTR_WIDTH),
      .DEPTH (DEPTH)
   ) u_program_memory (
      .clock_i   (clock_in),
      .wr_en_i   (mem_we),
      .wr_addr_i (load_address_in),
      .wr_data_i (load_data_in),
      .rd_addr_i (pc_d),
      .rd_data_o (rd_data)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      count_d = count_q;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      issue   = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_in) begin
               state_d = ST_FETCH;
               pc_d    = '0;
               count_d = '0;
            end
         end
         ST_FETCH: begin
            state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (rd_data == END_MARKER) begin
               state_d = ST_DONE;
            end
`ifdef INSTR_SEQ_BREAKPOINT_EN
            else if (breakpoint_enable_in && (pc_q == breakpoint_address_in)) begin
               state_d = ST_PAUSED;
            end
`endif
            else if (!stall_in) begin
               issue = 1'b1;
            end
         end
`ifdef INSTR_SEQ_BREAKPOINT_EN
         ST_PAUSED: begin
            if (resume_in) begin
               issue = 1'b1;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (issue) begin
         valid_d = 1'b1;
         instr_d = rd_data;
         count_d = count_q + (AW + 1)'(1);
         if (pc_q == PC_LAST) begin
            state_d = ST_DONE;
         end else begin
            pc_d    = pc_q + AW'(1);
            state_d = ST_ISSUE;
         end
      end

      if (abort_in) begin
         state_d = ST_IDLE;
         pc_d    = pc_q;
         count_d = count_q;
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end
   end

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
      end
   end

   assign current_instruction_out = instr_q;
   assign instruction_valid_out   = valid_q;
   assign instruction_count_out   = count_q;
   assign running_out             = (state_q == ST_FETCH) || (state_q == ST_ISSUE);
   assign done_out                = (state_q == ST_DONE);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: a default-depth instance and a DEPTH=4 instance.
// Breakpoint scenario is compiled only when INSTR_SEQ_BREAKPOINT_EN is defined.
module tb_instruction_sequencer;

   logic        clock_in = 1'b0;
   logic        reset_n_in;
   logic        load_enable_in;
   logic [9:0]  load_address_in;
   logic [15:0] load_data_in;
   logic        start_in, abort_in, stall_in;
   logic [15:0] current_instruction_out;
   logic        instruction_valid_out;
   logic [10:0] instruction_count_out;
   logic        running_out, done_out;

   logic        d4_load_enable_in;
   logic [1:0]  d4_load_address_in;
   logic [15:0] d4_load_data_in;
   logic        d4_start_in;
   logic [15:0] d4_current_instruction_out;
   logic        d4_instruction_valid_out;
   logic [2:0]  d4_instruction_count_out;
   logic        d4_running_out, d4_done_out;

`ifdef INSTR_SEQ_BREAKPOINT_EN
   logic        breakpoint_enable_in;
   logic [9:0]  breakpoint_address_in;
   logic        resume_in;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock_in = ~clock_in;

   instruction_sequencer u_dut (
      .clock_in                (clock_in),
      .reset_n_in              (reset_n_in),
      .load_enable_in          (load_enable_in),
      .load_address_in         (load_address_in),
      .load_data_in            (load_data_in),
      .start_in                (start_in),
      .abort_in                (abort_in),
      .stall_in                (stall_in),
`ifdef INSTR_SEQ_BREAKPOINT_EN
      .breakpoint_enable_in    (breakpoint_enable_in),
      .breakpoint_address_in   (breakpoint_address_in),
      .resume_in               (resume_in),
`endif
      .current_instruction_out (current_instruction_out),
      .instruction_valid_out   (instruction_valid_out),
      .instruction_count_out   (instruction_count_out),
      .running_out             (running_out),
      .done_out                (done_out)
   );

   instruction_sequencer #(.DEPTH(4)) u_dut4 (
      .clock_in                (clock_in),
      .reset_n_in              (reset_n_in),
      .load_enable_in          (d4_load_enable_in),
      .load_address_in         (d4_load_address_in),
      .load_data_in            (d4_load_data_in),
      .start_in                (d4_start_in),
      .abort_in                (1'b0),
      .stall_in                (1'b0),
`ifdef INSTR_SEQ_BREAKPOINT_EN
      .breakpoint_enable_in    (1'b0),
      .breakpoint_address_in   (2'd0),
      .resume_in               (1'b0),
`endif
      .current_instruction_out (d4_current_instruction_out),
      .instruction_valid_out   (d4_instruction_valid_out),
      .instruction_count_out   (d4_instruction_count_out),
      .running_out             (d4_running_out),
      .done_out                (d4_done_out)
   );

   // Observation word: {valid, instruction, count, running, done}
   function automatic logic [29:0] mk(input logic v, input logic [15:0] i, input int c,
                                      input logic r, input logic d);
      return {v, i, c[10:0], r, d};
   endfunction

   function automatic logic [29:0] snap();
      return {instruction_valid_out, current_instruction_out, instruction_count_out,
              running_out, done_out};
   endfunction

   function automatic logic [21:0] mk4(input logic v, input logic [15:0] i, input int c,
                                       input logic r, input logic d);
      return {v, i, c[2:0], r, d};
   endfunction

   function automatic logic [21:0] snap4();
      return {d4_instruction_valid_out, d4_current_instruction_out, d4_instruction_count_out,
              d4_running_out, d4_done_out};
   endfunction

   task automatic step();
      @(posedge clock_in);
      #1;
   endtask

   task automatic load(input logic [9:0] addr, input logic [15:0] data);
      load_enable_in  = 1'b1;
      load_address_in = addr;
      load_data_in    = data;
      step();
      load_enable_in  = 1'b0;
   endtask

   task automatic pulse_start();
      start_in = 1'b1;
      step();
      start_in = 1'b0;
   endtask

   task automatic test_reset();
      logic [29:0] got, exp;
      logic [21:0] got4, exp4;
      #12;
      got = snap(); exp = mk(0, 16'h9000, 0, 0, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_outputs: got %h required %h", got, exp); end
      got4 = snap4(); exp4 = mk4(0, 16'h9000, 0, 0, 0); checks++;
      if (got4 !== exp4) begin errors++; $display("FAIL reset_outputs_d4: got %h required %h", got4, exp4); end
      #1 reset_n_in = 1'b1;
      step();
      got = snap(); checks++;
      if (got !== exp) begin errors++; $display("FAIL idle_after_release: got %h required %h", got, exp); end
   endtask

   task automatic test_basic();
      logic [29:0] got;
      logic [29:0] exp [5];
      exp[0] = mk(0, 16'h9000, 0, 1, 0);
      exp[1] = mk(0, 16'h9000, 0, 1, 0);
      exp[2] = mk(1, 16'h0123, 1, 1, 0);
      exp[3] = mk(1, 16'h1456, 2, 1, 0);
      exp[4] = mk(0, 16'h9000, 2, 0, 1);
      load(10'd0, 16'h0123);
      load(10'd1, 16'h1456);
      load(10'd2, 16'hFFFF);
      pulse_start();
      for (int k = 0; k < 5; k++) begin
         if (k > 0) step();
         got = snap(); checks++;
         if (got !== exp[k]) begin
            errors++; $display("FAIL basic step %0d: got %h required %h", k, got, exp[k]);
         end
      end
   endtask

   task automatic test_stall();
      logic [29:0] got, exp;
      pulse_start();
      got = snap(); exp = mk(0, 16'h9000, 0, 1, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL stall_restart_clear: got %h required %h", got, exp); end
      step();
      step();
      got = snap(); exp = mk(1, 16'h0123, 1, 1, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL stall_first_issue: got %h required %h", got, exp); end
      stall_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         got = snap(); exp = mk(0, 16'h9000, 1, 1, 0); checks++;
         if (got !== exp) begin errors++; $display("FAIL stall cycle %0d: got %h required %h", k, got, exp); end
      end
      stall_in = 1'b0;
      step();
      got = snap(); exp = mk(1, 16'h1456, 2, 1, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL stall_release_issue: got %h required %h", got, exp); end
      step();
      got = snap(); exp = mk(0, 16'h9000, 2, 0, 1); checks++;
      if (got !== exp) begin errors++; $display("FAIL stall_done: got %h required %h", got, exp); end
   endtask

   task automatic test_abort();
      logic [29:0] got, exp;
      load(10'd2, 16'h2222);
      load(10'd3, 16'hFFFF);
      pulse_start();
      step();
      step();
      got = snap(); exp = mk(1, 16'h0123, 1, 1, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL abort_pre_issue: got %h required %h", got, exp); end
      abort_in = 1'b1;
      step();
      abort_in = 1'b0;
      got = snap(); exp = mk(0, 16'h9000, 1, 0, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL abort_to_idle: got %h required %h", got, exp); end
      step();
      got = snap(); checks++;
      if (got !== exp) begin errors++; $display("FAIL abort_idle_hold: got %h required %h", got, exp); end
      pulse_start();
      load_enable_in  = 1'b1;
      load_address_in = 10'd2;
      load_data_in    = 16'hAAAA;
      step();
      load_enable_in  = 1'b0;
      got = snap(); exp = mk(0, 16'h9000, 0, 1, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL abort_refetch: got %h required %h", got, exp); end
      step();
      got = snap(); exp = mk(1, 16'h0123, 1, 1, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL abort_restart_addr0: got %h required %h", got, exp); end
      start_in = 1'b1;
      step();
      start_in = 1'b0;
      got = snap(); exp = mk(1, 16'h1456, 2, 1, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL start_ignored_running: got %h required %h", got, exp); end
      step();
      got = snap(); exp = mk(1, 16'h2222, 3, 1, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL write_ignored_running: got %h required %h", got, exp); end
      step();
      got = snap(); exp = mk(0, 16'h9000, 3, 0, 1); checks++;
      if (got !== exp) begin errors++; $display("FAIL abort_rerun_done: got %h required %h", got, exp); end
   endtask

   task automatic test_reset_mid_run();
      logic [29:0] got, exp;
      int valid_seen;
      pulse_start();
      step();
      step();
      got = snap(); exp = mk(1, 16'h0123, 1, 1, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL rst_mid_pre: got %h required %h", got, exp); end
      #2 reset_n_in = 1'b0;
      #1;
      got = snap(); exp = mk(0, 16'h9000, 0, 0, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL rst_mid_async: got %h required %h", got, exp); end
      @(posedge clock_in);
      #2 reset_n_in = 1'b1;
      valid_seen = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (snap() !== exp) valid_seen++;
      end
      checks++;
      if (valid_seen != 0) begin
         errors++; $display("FAIL rst_mid_quiet: got %0d non-idle cycles required 0", valid_seen);
      end
      pulse_start();
      step();
      step();
      got = snap(); exp = mk(1, 16'h0123, 1, 1, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL rst_mem_retained: got %h required %h", got, exp); end
      abort_in = 1'b1;
      step();
      abort_in = 1'b0;
   endtask

   task automatic test_depth_limit();
      logic [21:0] got, exp;
      for (int a = 0; a < 4; a++) begin
         d4_load_enable_in  = 1'b1;
         d4_load_address_in = a[1:0];
         d4_load_data_in    = 16'hA000 + 16'(a);
         step();
      end
      d4_load_enable_in = 1'b0;
      d4_start_in = 1'b1;
      step();
      d4_start_in = 1'b0;
      step();
      for (int k = 0; k < 4; k++) begin
         step();
         got = snap4(); exp = mk4(1, 16'hA000 + 16'(k), k + 1, k < 3, k == 3); checks++;
         if (got !== exp) begin errors++; $display("FAIL depth4 issue %0d: got %h required %h", k, got, exp); end
      end
      for (int k = 0; k < 3; k++) begin
         step();
         got = snap4(); exp = mk4(0, 16'h9000, 4, 0, 1); checks++;
         if (got !== exp) begin errors++; $display("FAIL depth4 no_wrap %0d: got %h required %h", k, got, exp); end
      end
   endtask

`ifdef INSTR_SEQ_BREAKPOINT_EN
   task automatic test_breakpoint();
      logic [29:0] got, exp;
      breakpoint_enable_in  = 1'b1;
      breakpoint_address_in = 10'd1;
      pulse_start();
      step();
      step();
      got = snap(); exp = mk(1, 16'h0123, 1, 1, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL bp_first_issue: got %h required %h", got, exp); end
      for (int k = 0; k < 2; k++) begin
         step();
         got = snap(); exp = mk(0, 16'h9000, 1, 0, 0); checks++;
         if (got !== exp) begin errors++; $display("FAIL bp_paused %0d: got %h required %h", k, got, exp); end
      end
      resume_in = 1'b1;
      step();
      resume_in = 1'b0;
      got = snap(); exp = mk(1, 16'h1456, 2, 1, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL bp_resume_issue: got %h required %h", got, exp); end
      step();
      got = snap(); exp = mk(1, 16'h2222, 3, 1, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL bp_continue: got %h required %h", got, exp); end
      breakpoint_enable_in = 1'b0;
   endtask
`endif

   initial begin
      reset_n_in         = 1'b0;
      load_enable_in     = 1'b0;
      load_address_in    = '0;
      load_data_in       = '0;
      start_in           = 1'b0;
      abort_in           = 1'b0;
      stall_in           = 1'b0;
      d4_load_enable_in  = 1'b0;
      d4_load_address_in = '0;
      d4_load_data_in    = '0;
      d4_start_in        = 1'b0;
`ifdef INSTR_SEQ_BREAKPOINT_EN
      breakpoint_enable_in  = 1'b0;
      breakpoint_address_in = '0;
      resume_in             = 1'b0;
`endif
      test_reset();
      test_basic();
      test_stall();
      test_abort();
      test_reset_mid_run();
      test_depth_limit();
`ifdef INSTR_SEQ_BREAKPOINT_EN
      test_breakpoint();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
